fu_alu_issue_sink: RTL and testbench
====================================

FU_ALU_ISSUE_SINK -- requirements
Module: fu_alu_issue_sink

Interface
REQ-001 SHALL have parameter DEPTH_SKID, default 1; number of skid entries, legal values 1 only, used only when FU_ALU_SKID_EN is defined.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  kills all in-flight results.
REQ-005 SHALL have port issue_valid  input  1  integer RS presents an entry.
REQ-006 SHALL have port issue_ready  output  1  block accepts the entry this cycle.
REQ-007 SHALL have port issue_entry  input  int_rs_reg_t  issued operands and tags.
REQ-008 SHALL have port cdb_valid  output  1  result available for the CDB.
REQ-009 SHALL have port cdb_ready  input  1  CDB arbiter grant; result consumed this cycle.
REQ-010 SHALL have port cdb_entry  output  fu_alu_reg_t  rob_id, rd_arch, rd_phy, rd_value.

Function
REQ-011 SHALL accept an entry on any rising edge where issue_valid and issue_ready are both 1 and flush is 0.
REQ-012 SHALL select op1 as rs1_value (op1_sel 00), 0 (01), pc (10), 0 (11).
REQ-013 SHALL select op2 as rs2_value (op2_sel 00), 0 (01), immediate (10), 0 (11).
REQ-014 SHALL form the immediate as {imm_packed, 12'b0} when op1_sel is 01 or 10, else as sign-extended imm_packed[11:0].
REQ-015 SHALL compute rd_value from fu_opcode: 0 add, 1 sll, 2 sra, 3 sub, 4 xor, 5 srl, 6 or, 7 and, 8 signed slt, 9 unsigned sltu; opcodes 10-15 yield 0.
REQ-016 SHALL use op2[4:0] as the shift amount, and SLT/SLTU SHALL produce 32'd1 or 32'd0.
REQ-017 SHALL wrap add/sub results modulo 2^32 with no overflow flag.
REQ-018 SHALL pass rob_id, rd_arch, rd_phy unchanged from issue_entry to cdb_entry.
REQ-019 SHALL register the result so that an entry accepted at edge N drives cdb_valid=1 after edge N.
REQ-020 SHALL hold cdb_valid and cdb_entry stable while cdb_valid=1 and cdb_ready=0.
REQ-021 SHALL, without FU_ALU_SKID_EN, drive issue_ready = !cdb_valid || cdb_ready (combinational).
REQ-022 SHALL allow accept and drain on the same edge, replacing the output register with the new result.
REQ-023 SHALL, when flush=1 at an edge, clear cdb_valid and the skid-valid bit and discard any entry presented that cycle.
REQ-024 SHALL keep cdb_valid=0 on the edge after a flush even if issue_valid was 1 during the flush.
REQ-025 SHALL ignore cdb_ready while cdb_valid=0.
REQ-026 SHALL emit results in acceptance order.

Reset
REQ-027 SHALL, while rst_n=0, force cdb_valid=0, skid valid=0, and cdb_entry fields to 0, independent of clk.
REQ-028 SHALL drive issue_ready=1 in reset.
REQ-029 SHALL accept no entry on the first edge after rst_n deasserts unless issue_valid=1 at that edge.
REQ-030 SHALL, on reset mid-drain, discard the pending result.

Configuration
REQ-031 SHALL, with FU_ALU_SKID_EN defined, add one skid register behind the output register and drive issue_ready = !skid_valid from a flop, with no combinational path from cdb_ready.
REQ-032 SHALL, with FU_ALU_SKID_EN defined, move an entry accepted while the output is stalled into the skid, and promote the skid to the output on the next cdb_ready edge.
REQ-033 SHALL, with FU_ALU_SKID_EN undefined, contain no skid state, and its behaviour SHALL be exactly REQ-021.

Verification
REQ-034 SHALL cover issue: fu_opcode 3, rs1_value 5, rs2_value 7, op sels 00/00, cdb_ready=1 -> rd_value 0xFFFFFFFE one cycle later, with rob_id echoed.
REQ-035 SHALL cover issue: fu_opcode 0, op1_sel 10, pc 0x1000, op2_sel 10, imm_packed 0x00001 -> rd_value 0x00002000 (AUIPC).
REQ-036 SHALL cover issue: fu_opcode 2, rs1 0x80000000, op2_sel 10, imm_packed 0x0001F -> rd_value 0xFFFFFFFF; fu_opcode 9 with 0xFFFFFFFF vs 1 -> 0.
REQ-037 SHALL cover cdb_ready held 0 for 3 cycles with issue_valid held 1 -> cdb_entry stable, issue_ready=0 (plain) or one extra accept then 0 (skid), in-order drain after release.
REQ-038 SHALL cover flush asserted with a pending result and a simultaneous issue -> cdb_valid=0 next cycle, and neither result ever appears.
REQ-039 SHALL cover rst_n pulsed low mid-cycle while cdb_valid=1 -> cdb_valid drops immediately, before the next clk edge.

Source files
------------

// File: rtl/fu_alu_issue_sink.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fu_alu_issue_sink: integer ALU stage between the RS issue port and the CDB.  |
// | Optional FU_ALU_SKID_EN adds a skid entry so issue_ready comes from a flop.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+

typedef struct packed {
  logic [4:0]  rob_id;
  logic [4:0]  rd_arch;
  logic [5:0]  rd_phy;
  logic [3:0]  fu_opcode;
  logic [1:0]  op1_sel;
  logic [1:0]  op2_sel;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic [31:0] pc;
  logic [19:0] imm_packed;
} int_rs_reg_t;

typedef struct packed {
  logic [4:0]  rob_id;
  logic [4:0]  rd_arch;
  logic [5:0]  rd_phy;
  logic [31:0] rd_value;
} fu_alu_reg_t;

module fu_alu_issue_sink #(
  parameter int DEPTH_SKID = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  int_rs_reg_t issue_entry,
  output logic        cdb_valid,
  input  logic        cdb_ready,
  output fu_alu_reg_t cdb_entry
);

  if (DEPTH_SKID != 1) begin : g_bad_depth
    $error("fu_alu_issue_sink: DEPTH_SKID must be 1");
  end

  logic        out_valid_q, out_valid_d;
  fu_alu_reg_t out_q, out_d;
  fu_alu_reg_t result;
  logic [31:0] op1, op2, imm;
  logic [4:0]  shamt;
  logic        accept, drain;

  // Upper-immediate form is used for LUI/AUIPC, which select op1 = 0 or pc.
  always_comb begin
    if (issue_entry.op1_sel == 2'b01 || issue_entry.op1_sel == 2'b10)
      imm = {issue_entry.imm_packed, 12'b0};
    else
      imm = {{20{issue_entry.imm_packed[11]}}, issue_entry.imm_packed[11:0]};

    case (issue_entry.op1_sel)
      2'b00:   op1 = issue_entry.rs1_value;
      2'b10:   op1 = issue_entry.pc;
      default: op1 = 32'd0;
    endcase

    case (issue_entry.op2_sel)
      2'b00:   op2 = issue_entry.rs2_value;
      2'b10:   op2 = imm;
      default: op2 = 32'd0;
    endcase

    shamt = op2[4:0];

    result.rob_id  = issue_entry.rob_id;
    result.rd_arch = issue_entry.rd_arch;
    result.rd_phy  = issue_entry.rd_phy;
    case (issue_entry.fu_opcode)
      4'd0:    result.rd_value = op1 + op2;
      4'd1:    result.rd_value = op1 << shamt;
      4'd2:    result.rd_value = $unsigned($signed(op1) >>> shamt);
      4'd3:    result.rd_value = op1 - op2;
      4'd4:    result.rd_value = op1 ^ op2;
      4'd5:    result.rd_value = op1 >> shamt;
      4'd6:    result.rd_value = op1 | op2;
      4'd7:    result.rd_value = op1 & op2;
      4'd8:    result.rd_value = {31'd0, ($signed(op1) < $signed(op2))};
      4'd9:    result.rd_value = {31'd0, (op1 < op2)};
      default: result.rd_value = 32'd0;
    endcase
  end

  assign drain  = out_valid_q & cdb_ready;
  assign accept = issue_valid & issue_ready & ~flush;

`ifdef FU_ALU_SKID_EN
  logic        skid_valid_q, skid_valid_d;
  fu_alu_reg_t skid_q, skid_d;

  assign issue_ready = ~skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // issue_ready is low here, so only a promotion can happen
      if (drain) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || cdb_ready) begin
        out_d       = result;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = result;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end
`else
  assign issue_ready = ~out_valid_q | cdb_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = result;
      out_valid_d = 1'b1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign cdb_valid = out_valid_q;
  assign cdb_entry = out_q;

endmodule
`default_nettype wire

// File: tb/tb_fu_alu_issue_sink.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_fu_alu_issue_sink: directed vector bench for fu_alu_issue_sink.          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_fu_alu_issue_sink;

`ifdef FU_ALU_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [19:0] imm;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  int_rs_reg_t issue_entry;
  logic        cdb_valid;
  logic        cdb_ready;
  fu_alu_reg_t cdb_entry;

  int checks = 0;
  int errors = 0;
  vec_t vecs[14];

  fu_alu_issue_sink #(.DEPTH_SKID(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_entry(issue_entry),
    .cdb_valid  (cdb_valid),
    .cdb_ready  (cdb_ready),
    .cdb_entry  (cdb_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_entry(input logic [4:0] rob, input logic [3:0] op,
                           input logic [1:0] s1, input logic [1:0] s2,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] pc, input logic [19:0] imm);
    issue_entry.rob_id     = rob;
    issue_entry.rd_arch    = rob ^ 5'h1f;
    issue_entry.rd_phy     = {1'b1, rob};
    issue_entry.fu_opcode  = op;
    issue_entry.op1_sel    = s1;
    issue_entry.op2_sel    = s2;
    issue_entry.rs1_value  = rs1;
    issue_entry.rs2_value  = rs2;
    issue_entry.pc         = pc;
    issue_entry.imm_packed = imm;
  endtask

  initial begin
    //        op     s1     s2     rs1           rs2           pc            imm        expected
    vecs[0]  = '{4'd3, 2'b00, 2'b00, 32'd5,        32'd7,        32'd0,        20'h0,     32'hFFFF_FFFE};
    vecs[1]  = '{4'd0, 2'b10, 2'b10, 32'd0,        32'd0,        32'h1000,     20'h00001, 32'h0000_2000};
    vecs[2]  = '{4'd2, 2'b00, 2'b10, 32'h8000_0000, 32'd0,       32'd0,        20'h0001F, 32'hFFFF_FFFF};
    vecs[3]  = '{4'd9, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1,       32'd0,        20'h0,     32'd0};
    vecs[4]  = '{4'd8, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1,       32'd0,        20'h0,     32'd1};
    vecs[5]  = '{4'd1, 2'b00, 2'b00, 32'd1,        32'd4,        32'd0,        20'h0,     32'h10};
    vecs[6]  = '{4'd5, 2'b00, 2'b00, 32'h8000_0000, 32'd31,      32'd0,        20'h0,     32'd1};
    vecs[7]  = '{4'd4, 2'b00, 2'b00, 32'hF0F0,     32'h0FF0,     32'd0,        20'h0,     32'hFF00};
    vecs[8]  = '{4'd6, 2'b00, 2'b00, 32'hF0,       32'h0F,       32'd0,        20'h0,     32'hFF};
    vecs[9]  = '{4'd7, 2'b00, 2'b00, 32'hFF,       32'h3C,       32'd0,        20'h0,     32'h3C};
    vecs[10] = '{4'd12, 2'b00, 2'b00, 32'h1234,    32'h5678,     32'd0,        20'h0,     32'd0};
    vecs[11] = '{4'd0, 2'b00, 2'b10, 32'd10,       32'd0,        32'd0,        20'h00FFF, 32'd9};
    vecs[12] = '{4'd0, 2'b01, 2'b10, 32'hDEAD,     32'd0,        32'd0,        20'h12345, 32'h1234_5000};
    vecs[13] = '{4'd0, 2'b11, 2'b11, 32'hFFFF_FFFF, 32'd1,       32'h40,       20'h0,     32'd0};

    rst_n       = 1'b0;
    flush       = 1'b0;
    issue_valid = 1'b0;
    cdb_ready   = 1'b0;
    set_entry(5'd0, 4'd0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 20'h0);
    #12;
    chk("reset_cdb_valid", {31'd0, cdb_valid}, 32'd0);
    chk("reset_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("reset_rd_value", cdb_entry.rd_value, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {31'd0, cdb_valid}, 32'd0);

    // Back-to-back vectors with the CDB always granting
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      set_entry(5'(i + 1), vecs[i].op, vecs[i].s1, vecs[i].s2,
                vecs[i].rs1, vecs[i].rs2, vecs[i].pc, vecs[i].imm);
      issue_valid = 1'b1;
      cdb_ready   = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, cdb_valid}, 32'd1);
      chk($sformatf("vec%0d_value", i), cdb_entry.rd_value, vecs[i].exp);
      chk($sformatf("vec%0d_rob", i), {27'd0, cdb_entry.rob_id}, 32'(i + 1));
      chk($sformatf("vec%0d_phy", i), {26'd0, cdb_entry.rd_phy}, {26'd0, 1'b1, 5'(i + 1)});
    end
    @(negedge clk);
    issue_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_to_empty", {31'd0, cdb_valid}, 32'd0);

    // Stall: A held on the output while B waits
    @(negedge clk);
    set_entry(5'd21, 4'd0, 2'b00, 2'b00, 32'd1, 32'd1, 32'd0, 20'h0);
    issue_valid = 1'b1;
    cdb_ready   = 1'b0;
    @(posedge clk); #1;
    chk("stall_a_valid", {31'd0, cdb_valid}, 32'd1);
    @(negedge clk);
    set_entry(5'd22, 4'd0, 2'b00, 2'b00, 32'd2, 32'd2, 32'd0, 20'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_ready", k), {31'd0, issue_ready}, {31'd0, (SKID && k == 0)});
      @(posedge clk); #1;
      chk($sformatf("stall%0d_rob", k), {27'd0, cdb_entry.rob_id}, 32'd21);
      chk($sformatf("stall%0d_value", k), cdb_entry.rd_value, 32'd2);
      if (SKID && k == 0) issue_valid = 1'b0;
      @(negedge clk);
    end
    cdb_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_b_valid", {31'd0, cdb_valid}, 32'd1);
    chk("release_b_rob", {27'd0, cdb_entry.rob_id}, 32'd22);
    chk("release_b_value", cdb_entry.rd_value, 32'd4);
    @(negedge clk);
    issue_valid = 1'b0;
    @(posedge clk); #1;
    chk("release_empty", {31'd0, cdb_valid}, 32'd0);

    // Flush with a pending result and a simultaneous issue
    @(negedge clk);
    set_entry(5'd3, 4'd0, 2'b00, 2'b00, 32'd3, 32'd0, 32'd0, 20'h0);
    issue_valid = 1'b1;
    cdb_ready   = 1'b0;
    @(posedge clk); #1;
    chk("flush_pending", {31'd0, cdb_valid}, 32'd1);
    @(negedge clk);
    set_entry(5'd4, 4'd0, 2'b00, 2'b00, 32'd4, 32'd0, 32'd0, 20'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_clears", {31'd0, cdb_valid}, 32'd0);
    @(negedge clk);
    flush       = 1'b0;
    issue_valid = 1'b0;
    cdb_ready   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("flush_quiet%0d", k), {31'd0, cdb_valid}, 32'd0);
    end

    // Asynchronous reset in the middle of a stalled result
    @(negedge clk);
    set_entry(5'd9, 4'd0, 2'b00, 2'b00, 32'd9, 32'd0, 32'd0, 20'h0);
    issue_valid = 1'b1;
    cdb_ready   = 1'b0;
    @(posedge clk); #1;
    chk("arst_pending", {31'd0, cdb_valid}, 32'd1);
    issue_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_drop", {31'd0, cdb_valid}, 32'd0);
    chk("arst_rob_zero", {27'd0, cdb_entry.rob_id}, 32'd0);
    chk("arst_value_zero", cdb_entry.rd_value, 32'd0);
    chk("arst_ready", {31'd0, issue_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_discarded", {31'd0, cdb_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
